// File: rtl/serial_target_endpoint.sv
// Bit-serial bus target: deserializes address/write data and serves reads from a byte memory.
// Define SERIAL_TARGET_ERR_EN to add the bus_target_err abort pulse output.
module serial_target_endpoint #(
    parameter int unsigned MEM_DEPTH    = 4096,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        decoder_valid,
    input  logic        bus_data_in,
    input  logic        bus_data_in_valid,
    input  logic        bus_mode,
    input  logic        bus_rw,
    output logic        bus_data_out,
    output logic        bus_data_out_valid,
    output logic        bus_target_ack,
    output logic        bus_target_ready,
    output logic        wr_strobe,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data
`ifdef SERIAL_TARGET_ERR_EN
    ,
    output logic        bus_target_err
`endif
);

    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWdata,
        StWrite,
        StRwait,
        StRdata,
        StAck
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          ack_q, ack_d;
    logic          ready_q, ready_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [15:0]   wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          taken;
    logic          abort;
    logic [AW-1:0] idx;
    logic [7:0]    rd_byte;

    logic [7:0] mem [MEM_DEPTH];

    assign taken   = decoder_valid & bus_data_in_valid;
    // Address bits above the memory size are dropped for indexing only.
    assign idx     = addr_q[AW-1:0];
    assign rd_byte = mem[idx];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        ack_d        = 1'b0;
        wr_strobe_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        abort        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (taken && bus_mode) begin
                    addr_d    = {bus_data_in, addr_q[15:1]};
                    bit_cnt_d = 4'd1;
                    state_d   = StAddr;
                end
            end
            StAddr: begin
                if (!decoder_valid) begin
                    abort = 1'b1;
                end else if (taken) begin
                    if (!bus_mode) begin
                        abort = 1'b1;
                    end else begin
                        addr_d = {bus_data_in, addr_q[15:1]};
                        if (bit_cnt_q == 4'd15) begin
                            bit_cnt_d = 4'd0;
                            if (bus_rw) begin
                                state_d = StWdata;
                            end else begin
                                wait_cnt_d = 4'(READ_LATENCY);
                                state_d    = StRwait;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
            end
            StWdata: begin
                if (!decoder_valid) begin
                    abort = 1'b1;
                end else if (taken) begin
                    if (bus_mode) begin
                        abort = 1'b1;
                    end else begin
                        data_d = {bus_data_in, data_q[7:1]};
                        if (bit_cnt_q == 4'd7) begin
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = addr_q;
                            wr_data_d   = {bus_data_in, data_q[7:1]};
                            state_d     = StWrite;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
            end
            StWrite: begin
                ack_d   = 1'b1;
                state_d = StAck;
            end
            StRwait: begin
                if (wait_cnt_q <= 4'd1) begin
                    // Present bit 0 on entry so valid lines up with the first RDATA cycle.
                    dout_d       = rd_byte[0];
                    shift_d      = {1'b0, rd_byte[7:1]};
                    dout_valid_d = 1'b1;
                    bit_cnt_d    = 4'd0;
                    state_d      = StRdata;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StRdata: begin
                if (bit_cnt_q == 4'd7) begin
                    ack_d   = 1'b1;
                    state_d = StAck;
                end else begin
                    dout_d       = shift_q[0];
                    shift_d      = {1'b0, shift_q[7:1]};
                    dout_valid_d = 1'b1;
                    bit_cnt_d    = bit_cnt_q + 4'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort) begin
            state_d   = StIdle;
            bit_cnt_d = 4'd0;
        end

        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= 16'd0;
            data_q       <= 8'd0;
            shift_q      <= 8'd0;
            bit_cnt_q    <= 4'd0;
            wait_cnt_q   <= 4'd0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            ack_q        <= 1'b0;
            ready_q      <= 1'b1;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= 16'd0;
            wr_data_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ack_q        <= ack_d;
            ready_q      <= ready_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // A reset landing on the WRITE cycle cancels the commit.
    always_ff @(posedge clk) begin
        if (!rst && state_q == StWrite) begin
            mem[idx] <= data_q;
        end
    end

`ifdef SERIAL_TARGET_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= abort;
        end
    end

    assign bus_target_err = err_q;
`endif

    assign bus_data_out       = dout_q;
    assign bus_data_out_valid = dout_valid_q;
    assign bus_target_ack     = ack_q;
    assign bus_target_ready   = ready_q;
    assign wr_strobe          = wr_strobe_q;
    assign wr_addr            = wr_addr_q;
    assign wr_data            = wr_data_q;

endmodule

// File: tb/tb_serial_target_endpoint.sv
// Scoreboard bench for serial_target_endpoint: driver pushes expected events with their cycle,
// a negedge monitor pops and compares them as the DUT produces strobes, read bytes, acks, errors.
module tb_serial_target_endpoint;

    localparam int unsigned MEM_DEPTH    = 4096;
    localparam int unsigned READ_LATENCY = 2;
    localparam int unsigned RL           = READ_LATENCY;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        decoder_valid = 1'b0;
    logic        bus_data_in = 1'b0;
    logic        bus_data_in_valid = 1'b0;
    logic        bus_mode = 1'b0;
    logic        bus_rw = 1'b0;
    logic        bus_data_out;
    logic        bus_data_out_valid;
    logic        bus_target_ack;
    logic        bus_target_ready;
    logic        wr_strobe;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
`ifdef SERIAL_TARGET_ERR_EN
    logic        bus_target_err;
`endif

    serial_target_endpoint #(
        .MEM_DEPTH    (MEM_DEPTH),
        .READ_LATENCY (READ_LATENCY)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .decoder_valid      (decoder_valid),
        .bus_data_in        (bus_data_in),
        .bus_data_in_valid  (bus_data_in_valid),
        .bus_mode           (bus_mode),
        .bus_rw             (bus_rw),
        .bus_data_out       (bus_data_out),
        .bus_data_out_valid (bus_data_out_valid),
        .bus_target_ack     (bus_target_ack),
        .bus_target_ready   (bus_target_ready),
        .wr_strobe          (wr_strobe),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data)
`ifdef SERIAL_TARGET_ERR_EN
        ,
        .bus_target_err     (bus_target_err)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum logic [1:0] {EvWrite, EvRead, EvAck, EvErr} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        int unsigned at;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          allow_partial = 1'b0;
    logic [7:0]  mem_model [int];
    int          written_q[$];
    int          gap_before [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_check(input ev_kind_e kind, input int unsigned at, input logic [15:0] addr,
                             input logic [7:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: got event at cycle %0d expected none", kind.name(), at);
            return;
        end
        e = exp_q.pop_front();
        check($sformatf("%s_kind", e.kind.name()), 32'(kind), 32'(e.kind));
        check($sformatf("%s_cycle", e.kind.name()), at, e.at);
        if (e.kind == EvWrite) check("write_addr", 32'(addr), 32'(e.addr));
        if (e.kind == EvWrite || e.kind == EvRead) begin
            check($sformatf("%s_data", e.kind.name()), 32'(data), 32'(e.data));
        end
    endtask

    // Monitor: reassembles LSB-first read bytes and pops the scoreboard on every DUT event.
    int unsigned rd_bits = 0;
    int unsigned rd_start = 0;
    logic [7:0]  rd_byte = 8'd0;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) pop_check(EvWrite, cyc, wr_addr, wr_data);
        if (bus_data_out_valid === 1'b1) begin
            if (rd_bits == 0) rd_start = cyc;
            rd_byte[rd_bits[2:0]] = bus_data_out;
            rd_bits++;
            if (rd_bits == 8) begin
                pop_check(EvRead, rd_start, 16'd0, rd_byte);
                rd_bits = 0;
            end
        end else if (rd_bits != 0) begin
            if (!allow_partial) begin
                checks++;
                errors++;
                $display("FAIL read_burst: got %0d contiguous bits expected 8", rd_bits);
            end
            rd_bits = 0;
        end
        if (bus_target_ack === 1'b1) pop_check(EvAck, cyc, 16'd0, 8'd0);
`ifdef SERIAL_TARGET_ERR_EN
        if (bus_target_err === 1'b1) pop_check(EvErr, cyc, 16'd0, 8'd0);
`endif
    end

    function automatic int mem_idx(input logic [15:0] addr);
        return int'(addr) % int'(MEM_DEPTH);
    endfunction

    task automatic idle_drive();
        decoder_valid     = 1'($urandom);
        bus_data_in_valid = 1'($urandom);
        bus_mode          = 1'b0;
        bus_data_in       = 1'($urandom);
        bus_rw            = 1'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            idle_drive();
        end
    endtask

    task automatic drive_bit(input logic d, input logic m, input logic rw, input int gap);
        repeat (gap) begin
            @(negedge clk);
            decoder_valid     = 1'b1;
            bus_data_in_valid = 1'b0;
            bus_data_in       = 1'($urandom);
            bus_mode          = 1'($urandom);
            bus_rw            = 1'($urandom);
        end
        @(negedge clk);
        decoder_valid     = 1'b1;
        bus_data_in_valid = 1'b1;
        bus_data_in       = d;
        bus_mode          = m;
        bus_rw            = rw;
    endtask

    task automatic finish_txn(input int unsigned t);
        while (cyc < t) begin
            @(negedge clk);
            idle_drive();
            if (cyc == t - 1) check("ready_low_at_ack", 32'(bus_target_ready), 32'd0);
        end
        check("ready_after_ack", 32'(bus_target_ready), 32'd1);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        int unsigned n;
        for (int i = 0; i < 16; i++) begin
            drive_bit(addr[i], 1'b1, (i == 15) ? 1'b1 : 1'($urandom), gap_before[i]);
        end
        for (int i = 0; i < 8; i++) drive_bit(data[i], 1'b0, 1'($urandom), gap_before[16 + i]);
        n = cyc;
        exp_q.push_back('{EvWrite, n + 1, addr, data});
        exp_q.push_back('{EvAck, n + 2, 16'd0, 8'd0});
        if (!mem_model.exists(mem_idx(addr))) written_q.push_back(mem_idx(addr));
        mem_model[mem_idx(addr)] = data;
        finish_txn(n + 3);
    endtask

    task automatic do_read(input logic [15:0] addr);
        int unsigned n;
        for (int i = 0; i < 16; i++) begin
            drive_bit(addr[i], 1'b1, (i == 15) ? 1'b0 : 1'($urandom), gap_before[i]);
        end
        n = cyc;
        exp_q.push_back('{EvRead, n + RL + 1, addr, mem_model[mem_idx(addr)]});
        exp_q.push_back('{EvAck, n + RL + 9, 16'd0, 8'd0});
        finish_txn(n + RL + 10);
    endtask

    task automatic after_abort(input string name, input int unsigned k);
`ifdef SERIAL_TARGET_ERR_EN
        exp_q.push_back('{EvErr, k + 1, 16'd0, 8'd0});
`endif
        @(negedge clk);
        decoder_valid     = 1'b1;
        bus_data_in_valid = 1'b0;
        bus_mode          = 1'b0;
        check(name, 32'(bus_target_ready), 32'd1);
        idle_cycles(3);
    endtask

    task automatic abort_decoder(input logic [15:0] addr, input int nbits);
        for (int i = 0; i < nbits; i++) drive_bit(addr[i], 1'b1, 1'($urandom), 0);
        @(negedge clk);
        decoder_valid     = 1'b0;
        bus_data_in_valid = 1'($urandom);
        bus_mode          = 1'($urandom);
        after_abort("abort_dv_ready", cyc);
    endtask

    task automatic abort_mode(input logic [15:0] addr, input logic [7:0] data, input int nd);
        for (int i = 0; i < 16; i++) begin
            drive_bit(addr[i], 1'b1, (i == 15) ? 1'b1 : 1'($urandom), 0);
        end
        for (int i = 0; i < nd; i++) drive_bit(data[i], 1'b0, 1'($urandom), 0);
        drive_bit(1'($urandom), 1'b1, 1'($urandom), 0);
        after_abort("abort_mode_ready", cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, 32'(bus_data_out), 32'd0);
        check({tag, "_dout_valid"}, 32'(bus_data_out_valid), 32'd0);
        check({tag, "_ack"}, 32'(bus_target_ack), 32'd0);
        check({tag, "_ready"}, 32'(bus_target_ready), 32'd1);
        check({tag, "_wr_strobe"}, 32'(wr_strobe), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
`ifdef SERIAL_TARGET_ERR_EN
        check({tag, "_err"}, 32'(bus_target_err), 32'd0);
`endif
    endtask

    task automatic reset_during_read(input logic [15:0] addr);
        int unsigned n;
        for (int i = 0; i < 16; i++) begin
            drive_bit(addr[i], 1'b1, (i == 15) ? 1'b0 : 1'($urandom), 0);
        end
        n = cyc;
        allow_partial = 1'b1;
        while (cyc < n + RL + 4) begin
            @(negedge clk);
            idle_drive();
        end
        check("rdata_bit4_valid", 32'(bus_data_out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        idle_drive();
        check_reset_outputs("rst_rdata");
        rst = 1'b0;
        @(negedge clk);
        idle_drive();
        allow_partial = 1'b0;
        idle_cycles(2);
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < 24; i++) gap_before[i] = 0;
    endtask

    task automatic random_gaps();
        for (int i = 0; i < 24; i++) begin
            gap_before[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        int          pick;
        clear_gaps();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle_cycles(2);

        do_write(16'h00A5, 8'h3C);
        do_read(16'h00A5);
        do_write(16'h0010, 8'h81);
        do_read(16'h0010);
        do_write(16'hF123, 8'h77);
        do_read(16'h0123);

        gap_before[5]  = 3;
        gap_before[20] = 3;
        do_write(16'h00A5, 8'h3C);
        clear_gaps();
        do_read(16'h00A5);

        abort_decoder(16'h0123, 9);
        do_read(16'h0123);
        abort_mode(16'h00A5, 8'hFF, 3);
        do_read(16'h00A5);

        reset_during_read(16'h0010);
        do_read(16'h0010);

        for (int t = 0; t < 40; t++) begin
            random_gaps();
            if ($urandom_range(0, 1) == 0) begin
                do_write(16'($urandom), 8'($urandom));
            end else begin
                pick = written_q[$urandom_range(0, written_q.size() - 1)];
                a    = 16'($urandom) & ~16'(MEM_DEPTH - 1);
                a    = a | 16'(pick);
                do_read(a);
            end
            idle_cycles(int'($urandom_range(0, 3)));
        end
        clear_gaps();

        idle_cycles(5);
        check("pending_events", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
